// File: rtl/kmeans_sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_sram_arbiter_if
// Brief    : Requester, read-return and SRAM pin bundle for the k-means
//            point-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface kmeans_sram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_gnt;

    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_gnt;

    logic              rd_valid;
    logic              rd_id;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_web;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd0_req, rd0_addr,
        input  rd1_req, rd1_addr,
        input  mem_dout,
        output wr_gnt, rd0_gnt, rd1_gnt,
        output rd_valid, rd_id, rd_data,
        output mem_addr, mem_din, mem_web,
        output busy
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd0_req, rd0_addr,
        output rd1_req, rd1_addr,
        output mem_dout,
        input  wr_gnt, rd0_gnt, rd1_gnt,
        input  rd_valid, rd_id, rd_data,
        input  mem_addr, mem_din, mem_web,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/kmeans_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_sram_arbiter
// Brief    : Single-port point-SRAM scheduler: write-first priority with
//            per-reader aging, reader round-robin and a tagged read return.
// Revision : 1.0  initial release
// ============================================================================
module kmeans_sram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8,
    parameter int RD_LAT   = 3
) (
    input wire                   clk,
    input wire                   rst,
    kmeans_sram_arbiter_if.slave bus
);

    localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    logic [c_WAIT_W-1:0] wait0_q, wait0_d;
    logic [c_WAIT_W-1:0] wait1_q, wait1_d;
    logic                last_q, last_d;
    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [RD_LAT-1:0]   pid_q, pid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                mem_web_q, mem_web_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic w_starve0;
    logic w_starve1;
    logic w_gnt_wr;
    logic w_gnt_rd0;
    logic w_gnt_rd1;

    // Grant selection; last_q=1 means reader 1 was served last, so reader 0 wins a tie.
    always_comb begin
        w_starve0 = bus.rd0_req && (wait0_q >= c_WAIT_MAX);
        w_starve1 = bus.rd1_req && (wait1_q >= c_WAIT_MAX);
        w_gnt_wr  = 1'b0;
        w_gnt_rd0 = 1'b0;
        w_gnt_rd1 = 1'b0;
        if (w_starve0 && w_starve1) begin
            w_gnt_rd0 = last_q;
            w_gnt_rd1 = !last_q;
        end else if (w_starve0 || w_starve1) begin
            w_gnt_rd0 = w_starve0;
            w_gnt_rd1 = w_starve1;
        end else if (bus.wr_req) begin
            w_gnt_wr = 1'b1;
        end else if (bus.rd0_req && bus.rd1_req) begin
            w_gnt_rd0 = last_q;
            w_gnt_rd1 = !last_q;
        end else begin
            w_gnt_rd0 = bus.rd0_req;
            w_gnt_rd1 = bus.rd1_req;
        end
    end

    // Aging, pointer, SRAM command and return-pipeline next state.
    always_comb begin
        wait0_d = '0;
        if (bus.rd0_req && !w_gnt_rd0) begin
            wait0_d = (wait0_q == c_WAIT_MAX) ? wait0_q : wait0_q + 1'b1;
        end
        wait1_d = '0;
        if (bus.rd1_req && !w_gnt_rd1) begin
            wait1_d = (wait1_q == c_WAIT_MAX) ? wait1_q : wait1_q + 1'b1;
        end

        last_d = last_q;
        if (w_gnt_rd0) begin
            last_d = 1'b0;
        end else if (w_gnt_rd1) begin
            last_d = 1'b1;
        end

        mem_addr_d = mem_addr_q;
        mem_din_d  = '0;
        mem_web_d  = 1'b1;
        if (w_gnt_wr) begin
            mem_addr_d = bus.wr_addr;
            mem_din_d  = bus.wr_data;
            mem_web_d  = 1'b0;
        end else if (w_gnt_rd0) begin
            mem_addr_d = bus.rd0_addr;
        end else if (w_gnt_rd1) begin
            mem_addr_d = bus.rd1_addr;
        end

        pv_d  = {pv_q[RD_LAT-2:0], w_gnt_rd0 | w_gnt_rd1};
        pid_d = {pid_q[RD_LAT-2:0], w_gnt_rd1};

        // SRAM DO is valid one stage before the tag reaches the output.
        rd_data_d = pv_q[RD_LAT-2] ? bus.mem_dout : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait0_q    <= '0;
            wait1_q    <= '0;
            last_q     <= 1'b1;
            pv_q       <= '0;
            pid_q      <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_web_q  <= 1'b1;
            rd_data_q  <= '0;
        end else begin
            wait0_q    <= wait0_d;
            wait1_q    <= wait1_d;
            last_q     <= last_d;
            pv_q       <= pv_d;
            pid_q      <= pid_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_web_q  <= mem_web_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.wr_gnt   = w_gnt_wr;
    assign bus.rd0_gnt  = w_gnt_rd0;
    assign bus.rd1_gnt  = w_gnt_rd1;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_web  = mem_web_q;
    assign bus.rd_valid = pv_q[RD_LAT-1];
    assign bus.rd_id    = pid_q[RD_LAT-1];
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = |pv_q;

endmodule
`default_nettype wire
